// File: rtl/rgmii_link_speed_ctrl_pkg.sv
// rgmii_link_speed_ctrl_pkg: shared state encoding, speed codes and in-band status type
package rgmii_link_speed_ctrl_pkg;
   typedef enum logic [2:0] {DOWN, QUALIFY, RESTART, UP, DRAIN} state_e;
   localparam logic [1:0] SPD_10   = 2'b00;
   localparam logic [1:0] SPD_100  = 2'b01;
   localparam logic [1:0] SPD_1000 = 2'b10;
   localparam logic [1:0] SPD_NONE = 2'b11;
   typedef struct packed {
      logic       link;
      logic [1:0] speed;
      logic       duplex;
   } status_t;
   function automatic logic status_valid(input status_t s);
      return s.link && s.speed != SPD_NONE;
   endfunction
endpackage

// File: rtl/rgmii_link_speed_ctrl_if.sv
// rgmii_link_speed_ctrl_if: in-band status, client receive handshake and committed link outputs
interface rgmii_link_speed_ctrl_if;
   logic       link_status;
   logic [1:0] clock_speed;
   logic       duplex_status;
   logic       rx_data_valid;
   logic       rx_correct_frame;
   logic       rx_error_frame;
   logic       link_up;
   logic [1:0] speed_sel;
   logic       full_duplex;
   logic       mac_restart;
   logic       rx_accept;
   logic       link_change;
   logic [7:0] link_drop_cnt;
   modport master (
      output link_status, clock_speed, duplex_status, rx_data_valid, rx_correct_frame, rx_error_frame,
      input  link_up, speed_sel, full_duplex, mac_restart, rx_accept, link_change, link_drop_cnt
   );
   modport slave (
      input  link_status, clock_speed, duplex_status, rx_data_valid, rx_correct_frame, rx_error_frame,
      output link_up, speed_sel, full_duplex, mac_restart, rx_accept, link_change, link_drop_cnt
   );
endinterface

// File: rtl/rgmii_link_speed_ctrl_link_status_qualifier.sv
// link_status_qualifier: holds a candidate status and strobes commit after QUAL_CYCLES stable cycles
module link_status_qualifier
   import rgmii_link_speed_ctrl_pkg::*;
#(
   parameter int QUAL_CYCLES = 1024
) (
   input  logic       rx_rgmii_clk_int,
   input  logic       reset,
   input  logic       arm_i,
   input  logic       qual_en_i,
   input  status_t    sample_i,
   output logic [1:0] cand_speed_o,
   output logic       cand_duplex_o,
   output logic       commit_o
);
   localparam int CW = $clog2(QUAL_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(QUAL_CYCLES - 1);
   status_t       cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid, same, load, inc;
   always_comb begin
      valid    = status_valid(sample_i);
      same     = sample_i == cand_q;
      load     = valid && (arm_i || (qual_en_i && !same));
      inc      = valid && qual_en_i && same && cnt_q != CNT_LAST;
      commit_o = valid && qual_en_i && same && cnt_q == CNT_LAST;
      cand_d   = load ? sample_i : cand_q;
      cnt_d    = load ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge rx_rgmii_clk_int or posedge reset)
      if (reset) begin
         cand_q <= '0;
         cnt_q  <= '0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
      end
   assign cand_speed_o  = cand_q.speed;
   assign cand_duplex_o = cand_q.duplex;
endmodule

// File: rtl/rgmii_link_speed_ctrl.sv
// rgmii_link_speed_ctrl: commits RGMII in-band speed/duplex, sequences MAC restart and
// gates the client receive stream on frame boundaries
module rgmii_link_speed_ctrl
   import rgmii_link_speed_ctrl_pkg::*;
#(
   parameter int QUAL_CYCLES    = 1024,
   parameter int RESTART_CYCLES = 16,
   parameter int DRAIN_MAX      = 4096
) (
   input logic                    rx_rgmii_clk_int,
   input logic                    reset,
   rgmii_link_speed_ctrl_if.slave lnk_if
);
   localparam int RW = RESTART_CYCLES > 1 ? $clog2(RESTART_CYCLES) : 1;
   localparam int DW = DRAIN_MAX > 1 ? $clog2(DRAIN_MAX) : 1;
   localparam logic [RW-1:0] RST_LAST   = RW'(RESTART_CYCLES - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);
   state_e        state_q;
   logic [RW-1:0] rst_cnt_q;
   logic [DW-1:0] drain_cnt_q;
   logic          link_up_q, full_duplex_q, mac_restart_q, rx_accept_q, link_change_q;
   logic [1:0]    speed_sel_q, cand_speed;
   logic [7:0]    drop_cnt_q, drop_cnt_d;
   logic          cand_duplex, commit, valid, eof, mismatch, drain_done;
   status_t       sample;
   always_comb begin
      sample     = {lnk_if.link_status, lnk_if.clock_speed, lnk_if.duplex_status};
      valid      = status_valid(sample);
      eof        = lnk_if.rx_correct_frame || lnk_if.rx_error_frame;
      mismatch   = !valid || sample.speed != speed_sel_q || sample.duplex != full_duplex_q;
      drain_done = !rx_accept_q || !lnk_if.rx_data_valid || eof || drain_cnt_q == DRAIN_LAST;
      drop_cnt_d = drop_cnt_q == 8'hFF ? drop_cnt_q : drop_cnt_q + 8'd1;
   end
   link_status_qualifier #(.QUAL_CYCLES(QUAL_CYCLES)) u_qual (
      .rx_rgmii_clk_int (rx_rgmii_clk_int),
      .reset            (reset),
      .arm_i            (state_q == DOWN),
      .qual_en_i        (state_q == QUALIFY),
      .sample_i         (sample),
      .cand_speed_o     (cand_speed),
      .cand_duplex_o    (cand_duplex),
      .commit_o         (commit)
   );
   always_ff @(posedge rx_rgmii_clk_int or posedge reset)
      if (reset) begin
         state_q       <= DOWN;
         rst_cnt_q     <= '0;
         drain_cnt_q   <= '0;
         link_up_q     <= 1'b0;
         speed_sel_q   <= SPD_NONE;
         full_duplex_q <= 1'b0;
         mac_restart_q <= 1'b0;
         rx_accept_q   <= 1'b0;
         link_change_q <= 1'b0;
         drop_cnt_q    <= '0;
      end else begin
         link_change_q <= 1'b0;
         case (state_q)
            DOWN: if (valid) state_q <= QUALIFY;
            QUALIFY:
               if (!valid) state_q <= DOWN;
               else if (commit) begin
                  speed_sel_q   <= cand_speed;
                  full_duplex_q <= cand_duplex;
                  mac_restart_q <= 1'b1;
                  rst_cnt_q     <= '0;
                  state_q       <= RESTART;
               end
            RESTART:
               if (rst_cnt_q == RST_LAST) begin
                  mac_restart_q <= 1'b0;
                  link_up_q     <= 1'b1;
                  link_change_q <= 1'b1;
                  state_q       <= UP;
               end else rst_cnt_q <= rst_cnt_q + 1'b1;
            UP:
               if (mismatch) begin
                  drop_cnt_q  <= drop_cnt_d;
                  // a frame ending in the same cycle is already complete: leave DRAIN next cycle
                  drain_cnt_q <= eof ? DRAIN_LAST : '0;
                  state_q     <= DRAIN;
               end else if (!lnk_if.rx_data_valid) rx_accept_q <= 1'b1;
            DRAIN:
               if (drain_done) begin
                  rx_accept_q   <= 1'b0;
                  link_up_q     <= 1'b0;
                  speed_sel_q   <= SPD_NONE;
                  link_change_q <= 1'b1;
                  state_q       <= DOWN;
               end else drain_cnt_q <= drain_cnt_q + 1'b1;
            default: state_q <= DOWN;
         endcase
      end
   assign lnk_if.link_up       = link_up_q;
   assign lnk_if.speed_sel     = speed_sel_q;
   assign lnk_if.full_duplex   = full_duplex_q;
   assign lnk_if.mac_restart   = mac_restart_q;
   assign lnk_if.rx_accept     = rx_accept_q;
   assign lnk_if.link_change   = link_change_q;
   assign lnk_if.link_drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_rgmii_link_speed_ctrl.sv
// tb_rgmii_link_speed_ctrl: directed checks of qualification, restart, frame gating, drain and drop count
module tb_rgmii_link_speed_ctrl;
   import rgmii_link_speed_ctrl_pkg::*;
   localparam int Q = 32;
   localparam int R = 16;
   localparam int D = 64;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   rc, lc, rise, hit;
   always #5 clk = ~clk;
   rgmii_link_speed_ctrl_if bus ();
   rgmii_link_speed_ctrl #(.QUAL_CYCLES(Q), .RESTART_CYCLES(R), .DRAIN_MAX(D)) dut (
      .rx_rgmii_clk_int (clk),
      .reset            (reset),
      .lnk_if           (bus)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic st(input logic l, input logic [1:0] s, input logic d);
      bus.link_status   = l;
      bus.clock_speed   = s;
      bus.duplex_status = d;
   endtask
   task automatic updown();
      st(1'b1, SPD_10, 1'b0);
      cyc(Q + R + 2);
      st(1'b0, SPD_10, 1'b0);
      cyc(2);
   endtask
   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_link_up"}, bus.link_up, 0);
      chk({pfx, "_speed_sel"}, bus.speed_sel, 3);
      chk({pfx, "_full_duplex"}, bus.full_duplex, 0);
      chk({pfx, "_mac_restart"}, bus.mac_restart, 0);
      chk({pfx, "_rx_accept"}, bus.rx_accept, 0);
      chk({pfx, "_link_change"}, bus.link_change, 0);
      chk({pfx, "_drop_cnt"}, bus.link_drop_cnt, 0);
   endtask
   initial begin
      st(1'b0, SPD_NONE, 1'b0);
      bus.rx_data_valid    = 1'b0;
      bus.rx_correct_frame = 1'b0;
      bus.rx_error_frame   = 1'b0;
      cyc(3);
      chk_reset_outputs("rst");
      reset = 1'b0;
      cyc(2);
      chk("idle_link_up", bus.link_up, 0);
      // stable 1000M full: 16-cycle restart, link_up after Q+R+1 cycles
      st(1'b1, SPD_1000, 1'b1);
      rc = 0; lc = 0; rise = 0;
      for (int i = 1; i <= Q + R + 5; i++) begin
         cyc(1);
         rc += int'(bus.mac_restart);
         lc += int'(bus.link_change);
         if (bus.link_up && rise == 0) rise = i;
      end
      chk("restart_width", rc, R);
      chk("link_change_pulses", lc, 1);
      chk("link_up_latency", rise, Q + R + 1);
      chk("up_speed", bus.speed_sel, 2);
      chk("up_duplex", bus.full_duplex, 1);
      chk("up_accept", bus.rx_accept, 1);
      // link lost mid-frame: accept holds until the frame ends
      bus.rx_data_valid = 1'b1;
      cyc(3);
      st(1'b0, SPD_1000, 1'b1);
      cyc(1);
      chk("drop_cnt_1", bus.link_drop_cnt, 1);
      chk("drain_accept_hold", bus.rx_accept, 1);
      chk("drain_link_up_hold", bus.link_up, 1);
      cyc(3);
      chk("drain_accept_hold2", bus.rx_accept, 1);
      bus.rx_correct_frame = 1'b1;
      cyc(1);
      bus.rx_correct_frame = 1'b0;
      bus.rx_data_valid    = 1'b0;
      chk("eof_accept_off", bus.rx_accept, 0);
      chk("eof_link_down", bus.link_up, 0);
      chk("eof_speed_none", bus.speed_sel, 3);
      chk("eof_link_change", bus.link_change, 1);
      cyc(1);
      chk("link_change_single", bus.link_change, 0);
      // UP entered mid-frame: accept waits for the first idle cycle
      bus.rx_data_valid = 1'b1;
      st(1'b1, SPD_100, 1'b0);
      cyc(60);
      chk("busy_link_up", bus.link_up, 1);
      chk("busy_speed", bus.speed_sel, 1);
      chk("busy_duplex", bus.full_duplex, 0);
      chk("busy_accept_low", bus.rx_accept, 0);
      bus.rx_data_valid = 1'b0;
      cyc(1);
      chk("idle_accept_rise", bus.rx_accept, 1);
      // speed change with a frame that never ends: forced exit after D drain cycles
      bus.rx_data_valid = 1'b1;
      cyc(1);
      st(1'b1, SPD_1000, 1'b0);
      cyc(1);
      chk("drop_cnt_2", bus.link_drop_cnt, 2);
      cyc(D - 1);
      chk("force_drain_hold", bus.link_up, 1);
      cyc(1);
      chk("force_drain_down", bus.link_up, 0);
      chk("force_drain_accept", bus.rx_accept, 0);
      st(1'b0, SPD_1000, 1'b0);
      bus.rx_data_valid = 1'b0;
      cyc(2);
      // speed flapping faster than qualification never commits
      hit = 0;
      for (int k = 0; k < 10; k++) begin
         st(1'b1, (k % 2) != 0 ? SPD_1000 : SPD_100, 1'b1);
         for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (bus.mac_restart || bus.link_up) hit++;
         end
      end
      chk("flap_no_commit", hit, 0);
      st(1'b0, SPD_100, 1'b1);
      cyc(2);
      // end-of-frame coincides with link loss: drain ends next cycle despite a new frame
      st(1'b1, SPD_1000, 1'b1);
      cyc(Q + R + 3);
      chk("sim_accept", bus.rx_accept, 1);
      bus.rx_data_valid = 1'b1;
      cyc(2);
      st(1'b0, SPD_1000, 1'b1);
      bus.rx_correct_frame = 1'b1;
      cyc(1);
      bus.rx_correct_frame = 1'b0;
      chk("sim_drain_entry", bus.link_up, 1);
      chk("drop_cnt_3", bus.link_drop_cnt, 3);
      cyc(1);
      chk("sim_drain_exit", bus.link_up, 0);
      bus.rx_data_valid = 1'b0;
      // drop counter saturation over 300 more up/down cycles
      repeat (251) updown();
      chk("drop_cnt_254", bus.link_drop_cnt, 254);
      chk("updown_link_down", bus.link_up, 0);
      updown();
      chk("drop_cnt_255", bus.link_drop_cnt, 255);
      repeat (48) updown();
      chk("drop_cnt_sat", bus.link_drop_cnt, 255);
      // asynchronous reset in the middle of the restart pulse
      st(1'b1, SPD_1000, 1'b1);
      cyc(Q + 6);
      chk("pre_reset_restart", bus.mac_restart, 1);
      chk("pre_reset_speed", bus.speed_sel, 2);
      reset = 1'b1;
      #1;
      chk_reset_outputs("async");
      cyc(2);
      reset = 1'b0;
      cyc(1);
      chk("no_partial_restart", bus.mac_restart, 0);
      cyc(Q);
      chk("restart_after_reset", bus.mac_restart, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
